// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
//   fetch_state_e : fetch FSM state encoding
//   ILEN          : instruction width in bits
//   PC_STEP       : byte increment between sequential instructions
//   NOP_INSTR     : addi x0, x0, 0, shown on idata while nothing has been fetched
package instr_fetch_pkg;

  localparam int unsigned ILEN    = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    FAULT
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read port between the fetch stage and memory.
//   req    : one-cycle read request strobe (fetch -> memory)
//   addr   : read address, valid while req is high (fetch -> memory)
//   rvalid : read data valid, earliest one cycle after req (memory -> fetch)
//   rdata  : instruction word, qualified by rvalid (memory -> fetch)
interface instr_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) ();

  logic            req;
  logic [XLEN-1:0] addr;
  logic            rvalid;
  logic [ILEN-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/instr_fetch.sv
// Fetch stage of the RV32I core: holds the PC, issues one instruction-memory
// read at a time and presents the returned word to decode until it is consumed.
// Branch/jump redirects retarget the PC and flush any read in flight.
//   clk            : core clock, rising edge
//   reset_n        : asynchronous active-low reset
//   imem           : instruction-memory read port (master side)
//   idata          : instruction presented to decode/ALU
//   instr_pc       : PC of idata
//   instr_valid    : idata/instr_pc are valid
//   instr_ready    : core retires the presented instruction this cycle
//   redirect       : take redirect_pc as next PC and flush
//   redirect_pc    : branch/jump target
//   fetch_misalign : sticky misaligned-target fault flag
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  instr_fetch_if.master        imem,
  output logic [ILEN-1:0]      idata,
  output logic [XLEN-1:0]      instr_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 redirect,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic                 fetch_misalign
);

  localparam logic [XLEN-1:0] PcStep = XLEN'(PC_STEP);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  // Misaligned redirect seen while a read was in flight: enter FAULT once it returns.
  logic            pend_q, pend_d;
  logic [ILEN-1:0] idata_q, idata_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            valid_q, valid_d;
  logic            misalign_q, misalign_d;

  logic redir_ok, redir_bad;

  assign redir_ok  = redirect && (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect && (redirect_pc[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    pend_d     = pend_q;
    idata_d    = idata_q;
    ipc_d      = ipc_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;

    // A redirect always retargets the PC and sets or clears the fault flag.
    if (redirect) begin
      pc_d       = redirect_pc;
      misalign_d = redir_bad;
    end

    unique case (state_q)
      IDLE: begin
        state_d = redir_bad ? FAULT : REQ;
      end
      REQ: begin
        state_d = WAIT;
        if (redirect) begin
          kill_d = 1'b1;
          pend_d = redir_bad;
        end
      end
      WAIT: begin
        if (redirect) begin
          kill_d = 1'b1;
          pend_d = redir_bad;
        end
        if (imem.rvalid) begin
          kill_d = 1'b0;
          pend_d = 1'b0;
          // A redirect in this same cycle overrides whatever was pending.
          if (redir_bad || (!redirect && pend_q)) begin
            state_d = FAULT;
          end else if (redirect || kill_q) begin
            state_d = REQ;
          end else begin
            idata_d = imem.rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          valid_d = 1'b0;
          state_d = redir_bad ? FAULT : REQ;
        end else if (instr_ready) begin
          pc_d    = pc_q + PcStep;
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      FAULT: begin
        if (redir_ok) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      pend_q     <= 1'b0;
      idata_q    <= NOP_INSTR;
      ipc_q      <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      pend_q     <= pend_d;
      idata_q    <= idata_d;
      ipc_q      <= ipc_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem.req       = (state_q == REQ);
  assign imem.addr      = pc_q;
  assign idata          = idata_q;
  assign instr_pc       = ipc_q;
  assign instr_valid    = valid_q;
  assign fetch_misalign = misalign_q;

  // Only one read may be outstanding, so data can only legally return in WAIT.
  rvalid_only_in_wait: assert property (@(posedge clk) disable iff (!reset_n)
    imem.rvalid |-> (state_q == WAIT));

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam logic [31:0] MAGIC = 32'hA5A5_0000;
  localparam logic [31:0] BAD   = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, reset_n1;
  logic [31:0] idata0, ipc0, rpc0, idata1, ipc1, rpc1;
  logic        valid0, ready0, redir0, mis0, valid1, ready1, redir1, mis1;

  instr_fetch_if #(.XLEN(XLEN)) imem0 ();
  instr_fetch_if #(.XLEN(XLEN)) imem1 ();

  instr_fetch #(.XLEN(XLEN), .RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .reset_n(reset_n), .imem(imem0), .idata(idata0), .instr_pc(ipc0),
    .instr_valid(valid0), .instr_ready(ready0), .redirect(redir0), .redirect_pc(rpc0),
    .fetch_misalign(mis0)
  );

  instr_fetch #(.XLEN(XLEN), .RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .reset_n(reset_n1), .imem(imem1), .idata(idata1), .instr_pc(ipc1),
    .instr_valid(valid1), .instr_ready(ready1), .redirect(redir1), .redirect_pc(rpc1),
    .fetch_misalign(mis1)
  );

  int n_pass   = 0;
  int n_checks = 0;

  // Memory for dut0: answers each request after a latency, data = addr ^ MAGIC.
  int unsigned mem_lat  = 1;
  bit          rand_lat = 1'b0;
  bit          poison   = 1'b0;

  initial begin : mem0
    int unsigned cnt;
    logic [31:0] paddr;
    cnt = 0;
    paddr = '0;
    imem0.rvalid = 1'b0;
    imem0.rdata  = '0;
    forever begin
      @(negedge clk);
      imem0.rvalid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem0.rvalid = 1'b1;
          imem0.rdata  = poison ? BAD : (paddr ^ MAGIC);
        end
      end
      if (imem0.req === 1'b1) begin
        paddr = imem0.addr;
        cnt   = rand_lat ? $urandom_range(3, 1) : mem_lat;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid0(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (valid0 === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_req0(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (imem0.req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; reset_n1 = 1'b0;
    ready0 = 1'b0; redir0 = 1'b0; rpc0 = '0;
    ready1 = 1'b0; redir1 = 1'b0; rpc1 = '0;
    imem1.rvalid = 1'b0; imem1.rdata = '0;
    repeat (3) tick();
    n_checks++; if (imem0.req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem0.req); else n_pass++;
    n_checks++; if (imem0.addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", imem0.addr); else n_pass++;
    n_checks++; if (valid0 !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid0); else n_pass++;
    n_checks++; if (idata0 !== NOP_INSTR) $display("FAIL reset_idata: got %h want %h", idata0, NOP_INSTR); else n_pass++;
    n_checks++; if (ipc0 !== 32'h0) $display("FAIL reset_instr_pc: got %h want 0", ipc0); else n_pass++;
    n_checks++; if (mis0 !== 1'b0) $display("FAIL reset_misalign: got %b want 0", mis0); else n_pass++;
    reset_n = 1'b1;
  endtask

  task automatic test_stream();
    bit ok;
    int vc[$];
    logic [31:0] vp[$];
    ready0 = 1'b1;
    wait_req0(4, ok);
    n_checks++; if (!ok || imem0.addr !== 32'h0) $display("FAIL first_req: seen %b addr %h want addr 0", ok, imem0.addr); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      if (valid0 === 1'b1) begin
        vp.push_back(ipc0);
        vc.push_back(i);
        n_checks++; if (idata0 !== (ipc0 ^ MAGIC)) $display("FAIL stream_data: got %h want %h", idata0, ipc0 ^ MAGIC); else n_pass++;
      end
      tick();
    end
    n_checks++;
    if (vp.size() < 4) begin
      $display("FAIL stream_count: got %0d pulses want at least 4", vp.size());
    end else begin
      n_pass++;
      for (int k = 0; k < 4; k++) begin
        n_checks++; if (vp[k] !== 32'(4 * k)) $display("FAIL stream_pc%0d: got %h want %h", k, vp[k], 4 * k); else n_pass++;
      end
      for (int k = 1; k < 4; k++) begin
        n_checks++; if (vc[k] - vc[k-1] != 3) $display("FAIL stream_gap%0d: got %0d want 3", k, vc[k] - vc[k-1]); else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] p, d;
    ready0 = 1'b0;
    wait_valid0(10, ok);
    n_checks++; if (!ok) $display("FAIL stall_valid: got no instr_valid want 1"); else n_pass++;
    p = ipc0;
    d = idata0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({valid0, imem0.req, ipc0, idata0} !== {1'b1, 1'b0, p, d})
        $display("FAIL stall_hold%0d: got v%b r%b pc %h d %h want v1 r0 pc %h d %h",
                 i, valid0, imem0.req, ipc0, idata0, p, d);
      else n_pass++;
    end
    ready0 = 1'b1;
    tick();
    ready0 = 1'b0;
    wait_req0(4, ok);
    n_checks++; if (!ok || imem0.addr !== p + 32'd4) $display("FAIL stall_next: seen %b addr %h want %h", ok, imem0.addr, p + 32'd4); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    bit ok, got_req, saw_bad;
    logic [31:0] a;
    wait_valid0(10, ok);
    poison = 1'b1;
    mem_lat = 3;
    ready0 = 1'b1;
    tick();
    ready0 = 1'b0;
    wait_req0(2, ok);
    tick();
    redir0 = 1'b1; rpc0 = 32'h100;
    tick();
    redir0 = 1'b0;
    mem_lat = 1;
    got_req = 1'b0; saw_bad = 1'b0; a = '0;
    for (int i = 0; i < 12; i++) begin
      if (valid0 === 1'b1 && idata0 === BAD) saw_bad = 1'b1;
      if (!got_req && imem0.req === 1'b1) begin
        got_req = 1'b1;
        a = imem0.addr;
        poison = 1'b0;
      end
      if (got_req && valid0 === 1'b1) break;
      tick();
    end
    n_checks++; if (!got_req || a !== 32'h100) $display("FAIL kill_next_addr: seen %b addr %h want 100", got_req, a); else n_pass++;
    n_checks++; if (saw_bad) $display("FAIL kill_discard: got DEADBEEF on idata want never"); else n_pass++;
    n_checks++;
    if (valid0 !== 1'b1 || ipc0 !== 32'h100 || idata0 !== (32'h100 ^ MAGIC))
      $display("FAIL kill_target_instr: got v%b pc %h d %h want v1 pc 100 d %h", valid0, ipc0, idata0, 32'h100 ^ MAGIC);
    else n_pass++;
  endtask

  task automatic test_redirect_hold();
    bit ok;
    ready0 = 1'b1; redir0 = 1'b1; rpc0 = 32'h200;
    tick();
    ready0 = 1'b0; redir0 = 1'b0;
    n_checks++;
    if (imem0.req !== 1'b1 || imem0.addr !== 32'h200 || valid0 !== 1'b0)
      $display("FAIL hold_redirect: got r%b addr %h v%b want r1 addr 200 v0", imem0.req, imem0.addr, valid0);
    else n_pass++;
    wait_valid0(6, ok);
    n_checks++; if (!ok || ipc0 !== 32'h200) $display("FAIL hold_redirect_instr: got pc %h want 200", ipc0); else n_pass++;
  endtask

  task automatic test_misalign();
    bit ok;
    redir0 = 1'b1; rpc0 = 32'h102;
    tick();
    redir0 = 1'b0;
    n_checks++; if (mis0 !== 1'b1 || valid0 !== 1'b0) $display("FAIL misalign_set: got m%b v%b want m1 v0", mis0, valid0); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (imem0.req !== 1'b0 || mis0 !== 1'b1 || valid0 !== 1'b0)
        $display("FAIL fault_idle%0d: got r%b m%b v%b want r0 m1 v0", i, imem0.req, mis0, valid0);
      else n_pass++;
    end
    redir0 = 1'b1; rpc0 = 32'h300;
    tick();
    redir0 = 1'b0;
    n_checks++;
    if (mis0 !== 1'b0 || imem0.req !== 1'b1 || imem0.addr !== 32'h300)
      $display("FAIL fault_exit: got m%b r%b addr %h want m0 r1 addr 300", mis0, imem0.req, imem0.addr);
    else n_pass++;
    wait_valid0(6, ok);
    n_checks++; if (!ok || ipc0 !== 32'h300) $display("FAIL fault_exit_instr: got pc %h want 300", ipc0); else n_pass++;

    // Misaligned redirect while a read is outstanding.
    mem_lat = 2;
    ready0 = 1'b1;
    tick();
    ready0 = 1'b0;
    tick();
    redir0 = 1'b1; rpc0 = 32'h106;
    tick();
    redir0 = 1'b0;
    n_checks++;
    if (mis0 !== 1'b1 || imem0.req !== 1'b0 || valid0 !== 1'b0)
      $display("FAIL wait_misalign: got m%b r%b v%b want m1 r0 v0", mis0, imem0.req, valid0);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (imem0.req !== 1'b0 || mis0 !== 1'b1 || valid0 !== 1'b0)
        $display("FAIL wait_fault%0d: got r%b m%b v%b want r0 m1 v0", i, imem0.req, mis0, valid0);
      else n_pass++;
    end
    mem_lat = 1;
    redir0 = 1'b1; rpc0 = 32'h400;
    tick();
    redir0 = 1'b0;
    n_checks++;
    if (mis0 !== 1'b0 || imem0.req !== 1'b1 || imem0.addr !== 32'h400)
      $display("FAIL wait_fault_exit: got m%b r%b addr %h want m0 r1 addr 400", mis0, imem0.req, imem0.addr);
    else n_pass++;
    wait_valid0(6, ok);
  endtask

  // Program-order model: every presented instruction must be the next PC in sequence
  // (last + 4, or the latest redirect target) carrying that address's memory word.
  task automatic test_random();
    logic [31:0] exp_pc, last_pc, last_d;
    bit prev_valid;
    int n_instr;
    rand_lat = 1'b1;
    n_instr = 0;
    redir0 = 1'b1; rpc0 = 32'h1000; ready0 = 1'b0;
    exp_pc = 32'h1000;
    prev_valid = 1'b0; last_pc = '0; last_d = '0;
    tick();
    redir0 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (imem0.req === 1'b1) begin
        n_checks++; if (imem0.addr !== exp_pc) $display("FAIL rand_req_addr@%0d: got %h want %h", i, imem0.addr, exp_pc); else n_pass++;
      end
      if (valid0 === 1'b1 && !prev_valid) begin
        n_instr++;
        n_checks++; if (ipc0 !== exp_pc) $display("FAIL rand_pc@%0d: got %h want %h", i, ipc0, exp_pc); else n_pass++;
        n_checks++; if (idata0 !== (exp_pc ^ MAGIC)) $display("FAIL rand_data@%0d: got %h want %h", i, idata0, exp_pc ^ MAGIC); else n_pass++;
      end else if (valid0 === 1'b1) begin
        n_checks++;
        if (ipc0 !== last_pc || idata0 !== last_d)
          $display("FAIL rand_stable@%0d: got %h/%h want %h/%h", i, ipc0, idata0, last_pc, last_d);
        else n_pass++;
      end
      prev_valid = (valid0 === 1'b1);
      last_pc = ipc0;
      last_d  = idata0;
      ready0 = ($urandom_range(99, 0) < 70);
      redir0 = ($urandom_range(99, 0) < 8);
      rpc0   = $urandom & 32'h0000_FFFC;
      if (redir0) exp_pc = rpc0;
      else if (prev_valid && ready0) exp_pc = exp_pc + 32'd4;
      tick();
    end
    redir0 = 1'b0; ready0 = 1'b0; rand_lat = 1'b0;
    n_checks++; if (n_instr < 20) $display("FAIL rand_progress: got %0d instrs want >= 20", n_instr); else n_pass++;
  endtask

  task automatic test_wrap_reset();
    logic [31:0] addrs[$];
    logic [31:0] paddr, fpc, fdat;
    bit pend, seen;
    n_checks++; if (imem1.addr !== 32'hFFFF_FFFC) $display("FAIL wrap_reset_addr: got %h want FFFFFFFC", imem1.addr); else n_pass++;
    reset_n1 = 1'b1;
    ready1 = 1'b1;
    pend = 1'b0; seen = 1'b0; paddr = '0; fpc = '0; fdat = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      imem1.rvalid = pend;
      imem1.rdata  = paddr ^ MAGIC;
      pend = (imem1.req === 1'b1);
      if (pend) begin
        paddr = imem1.addr;
        addrs.push_back(imem1.addr);
      end
      if (valid1 === 1'b1 && !seen) begin
        seen = 1'b1; fpc = ipc1; fdat = idata1;
      end
      if (addrs.size() == 2) break;
    end
    n_checks++;
    if (addrs.size() != 2) begin
      $display("FAIL wrap_count: got %0d requests want 2", addrs.size());
    end else begin
      n_pass++;
      n_checks++; if (addrs[0] !== 32'hFFFF_FFFC) $display("FAIL wrap_first: got %h want FFFFFFFC", addrs[0]); else n_pass++;
      n_checks++; if (addrs[1] !== 32'h0) $display("FAIL wrap_second: got %h want 0", addrs[1]); else n_pass++;
    end
    n_checks++;
    if (!seen || fpc !== 32'hFFFF_FFFC || fdat !== 32'h5A5A_FFFC)
      $display("FAIL wrap_instr: got pc %h d %h want FFFFFFFC/5A5AFFFC", fpc, fdat);
    else n_pass++;
    // Now in WAIT with a read outstanding; reset without ever returning it.
    tick();
    imem1.rvalid = 1'b0;
    reset_n1 = 1'b0;
    #1;
    n_checks++;
    if (imem1.req !== 1'b0 || imem1.addr !== 32'hFFFF_FFFC || valid1 !== 1'b0 ||
        idata1 !== NOP_INSTR || ipc1 !== 32'h0 || mis1 !== 1'b0)
      $display("FAIL async_reset: got r%b addr %h v%b d %h pc %h m%b want r0 FFFFFFFC v0 %h 0 m0",
               imem1.req, imem1.addr, valid1, idata1, ipc1, mis1, NOP_INSTR);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_misalign();
    test_random();
    test_wrap_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
